// File: rtl/ip_vdp_port_responder.sv
// ip_vdp_port_responder: CPU-side port decoder for a VDP.
// Port 0 is the VRAM data port (auto-incrementing 17-bit address). Port 1
// is the two-byte address / register-write port. Port 2 is the two-byte
// palette port. Port 3 is the indirect register port.
// Optional feature macro: IP_VDP_PORT3_EN enables the port 3 indirect
// register writes and the R17 pointer behind them.
module ip_vdp_port_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ack,
  input  logic        wr,
  input  logic [1:0]  address,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        vram_req,
  input  logic        vram_ack,
  output logic        vram_wr,
  output logic [16:0] vram_address,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic        reg_we,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  output logic        pal_we,
  output logic [3:0]  pal_num,
  output logic [8:0]  pal_rgb
);

  typedef enum logic [1:0] {ST_IDLE, ST_VRAM, ST_ACK, ST_RELEASE} state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        flag1_q, flag1_d;       // port 1 first byte pending
  logic [7:0]  byte1_q, byte1_d;
  logic        palflag_q, palflag_d;   // port 2 first byte pending
  logic [2:0]  palr_q, palr_d;
  logic [2:0]  palb_q, palb_d;
  logic [16:0] vaddr_q, vaddr_d;
  logic [3:0]  r16_q, r16_d;           // palette pointer, only the low nibble matters
  logic [7:0]  rdata_q, rdata_d;
  logic        reg_we_q, reg_we_d;
  logic [5:0]  reg_num_q, reg_num_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        pal_we_q, pal_we_d;
  logic [3:0]  pal_num_q, pal_num_d;
  logic [8:0]  pal_rgb_q, pal_rgb_d;
`ifdef IP_VDP_PORT3_EN
  logic [5:0]  r17_num_q, r17_num_d;   // indirect register pointer
  logic        r17_hold_q, r17_hold_d; // R17[7]: suppress auto-increment
`endif

  // Register-write request gathered from port 1 or port 3, applied once below
  logic        rw_en;
  logic [5:0]  rw_num;
  logic [7:0]  rw_val;

  assign ack          = (state_q == ST_ACK);
  assign vram_req     = (state_q == ST_VRAM);
  assign vram_wr      = vram_req & wr_q;
  assign vram_address = vaddr_q;
  assign vram_wdata   = wdata_q;
  assign rdata        = rdata_q;
  assign reg_we       = reg_we_q;
  assign reg_num      = reg_num_q;
  assign reg_data     = reg_data_q;
  assign pal_we       = pal_we_q;
  assign pal_num      = pal_num_q;
  assign pal_rgb      = pal_rgb_q;

  // Next-state, side effects and one-cycle strobes (strobes land in ST_ACK)
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    flag1_d    = flag1_q;
    byte1_d    = byte1_q;
    palflag_d  = palflag_q;
    palr_d     = palr_q;
    palb_d     = palb_q;
    vaddr_d    = vaddr_q;
    r16_d      = r16_q;
    rdata_d    = 8'h00;
    reg_we_d   = 1'b0;
    reg_num_d  = 6'h00;
    reg_data_d = 8'h00;
    pal_we_d   = 1'b0;
    pal_num_d  = 4'h0;
    pal_rgb_d  = 9'h000;
    rw_en      = 1'b0;
    rw_num     = 6'h00;
    rw_val     = 8'h00;
`ifdef IP_VDP_PORT3_EN
    r17_num_d  = r17_num_q;
    r17_hold_d = r17_hold_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_d    = wr;
          wdata_d = wdata;
          case (address)
            2'd0: begin
              flag1_d = 1'b0;
              state_d = ST_VRAM;
            end
            2'd1: begin
              state_d = ST_ACK;
              if (!wr) begin
                flag1_d = 1'b0;
              end else if (!flag1_q) begin
                byte1_d = wdata;
                flag1_d = 1'b1;
              end else begin
                flag1_d = 1'b0;
                if (wdata[7]) begin
                  rw_en  = 1'b1;
                  rw_num = wdata[5:0];
                  rw_val = byte1_q;
                end else begin
                  vaddr_d[13:0] = {wdata[5:0], byte1_q};
                end
              end
            end
            2'd2: begin
              state_d = ST_ACK;
              if (wr) begin
                if (!palflag_q) begin
                  palr_d    = wdata[6:4];
                  palb_d    = wdata[2:0];
                  palflag_d = 1'b1;
                end else begin
                  pal_we_d  = 1'b1;
                  pal_num_d = r16_q;
                  pal_rgb_d = {palr_q, wdata[2:0], palb_q};
                  r16_d     = r16_q + 4'd1;
                  palflag_d = 1'b0;
                end
              end
            end
            default: begin
              state_d = ST_ACK;
`ifdef IP_VDP_PORT3_EN
              if (wr) begin
                rw_en  = 1'b1;
                rw_num = r17_num_q;
                rw_val = wdata;
                if (!r17_hold_q) r17_num_d = r17_num_q + 6'd1;
              end
`endif
            end
          endcase
        end
      end
      ST_VRAM: begin
        if (vram_ack) begin
          state_d = ST_ACK;
          if (!wr_q) rdata_d = vram_rdata;
          vaddr_d = vaddr_q + 17'd1;
        end
      end
      ST_ACK: state_d = ST_RELEASE;
      default: begin
        if (!req) state_d = ST_IDLE;
      end
    endcase

    // Register writes and the registers this block shadows
    if (rw_en) begin
      reg_we_d   = 1'b1;
      reg_num_d  = rw_num;
      reg_data_d = rw_val;
      if (rw_num == 6'd14) vaddr_d[16:14] = rw_val[2:0];
      if (rw_num == 6'd16) begin
        r16_d     = rw_val[3:0];
        palflag_d = 1'b0;
      end
`ifdef IP_VDP_PORT3_EN
      if (rw_num == 6'd17) begin
        r17_num_d  = rw_val[5:0];
        r17_hold_d = rw_val[7];
      end
`endif
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      wdata_q    <= 8'h00;
      flag1_q    <= 1'b0;
      byte1_q    <= 8'h00;
      palflag_q  <= 1'b0;
      palr_q     <= 3'd0;
      palb_q     <= 3'd0;
      vaddr_q    <= 17'd0;
      r16_q      <= 4'd0;
      rdata_q    <= 8'h00;
      reg_we_q   <= 1'b0;
      reg_num_q  <= 6'h00;
      reg_data_q <= 8'h00;
      pal_we_q   <= 1'b0;
      pal_num_q  <= 4'h0;
      pal_rgb_q  <= 9'h000;
`ifdef IP_VDP_PORT3_EN
      r17_num_q  <= 6'd0;
      r17_hold_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      flag1_q    <= flag1_d;
      byte1_q    <= byte1_d;
      palflag_q  <= palflag_d;
      palr_q     <= palr_d;
      palb_q     <= palb_d;
      vaddr_q    <= vaddr_d;
      r16_q      <= r16_d;
      rdata_q    <= rdata_d;
      reg_we_q   <= reg_we_d;
      reg_num_q  <= reg_num_d;
      reg_data_q <= reg_data_d;
      pal_we_q   <= pal_we_d;
      pal_num_q  <= pal_num_d;
      pal_rgb_q  <= pal_rgb_d;
`ifdef IP_VDP_PORT3_EN
      r17_num_q  <= r17_num_d;
      r17_hold_q <= r17_hold_d;
`endif
    end
  end

endmodule
